irq_dispatch: RTL and testbench

Interrupt dispatch sequencer placed directly downstream of the interrupt controller in BrainForge8. It consumes the pending interrupt identifier and valid flag, waits for an instruction boundary, and pushes the return PC onto the stack through the memory port. It then fetches the 16-bit handler vector from the vector table, loads PC/SP into the core, and pulses ACK so the controller retires the interrupt. The reset-boot interrupt (ID 8) bypasses the enable and boundary gates and the stack push.

---
 rtl/irq_pkg.sv | 22 ++
 rtl/irq_dispatch.sv | 161 ++++++++++++++++
 tb/tb_irq_dispatch.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// irq_pkg: shared interrupt-dispatch types and constants (state encoding, interrupt IDs, vector base).
// PUSH_FL exists only when IRQ_FLAGS_PUSH_EN is defined.
package irq_pkg;
  localparam logic [15:0] VEC_BASE_DEFAULT = 16'hFFE0;
  localparam logic [3:0]  INT_ID_RSTB      = 4'b1000;
  typedef enum logic [3:0] {
    S_IDLE,
    S_PUSH_HI,
    S_PUSH_LO,
`ifdef IRQ_FLAGS_PUSH_EN
    S_PUSH_FL,
`endif
    S_VEC_LO,
    S_VEC_HI,
    S_LOAD,
    S_DONE,
    S_DRAIN
  } state_t;
  function automatic logic [15:0] vec_addr(input logic [15:0] base, input logic [3:0] id, input logic hi);
    return base + {11'd0, id, hi};
  endfunction
endpackage

// File: rtl/irq_dispatch.sv
// irq_dispatch: interrupt entry sequencer -- push return PC, fetch handler vector, load PC/SP, ack.
// Define IRQ_FLAGS_PUSH_EN to also push FLAGS_IN at SP-3 (SP_OUT becomes SP_IN-3).
module irq_dispatch
  import irq_pkg::*;
#(
  parameter logic [15:0] VEC_BASE = VEC_BASE_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [3:0]  i_next_id,
  input  logic        i_next_on,
  output logic        o_ack,
  input  logic        i_ie,
  input  logic        i_boundary,
  input  logic [15:0] i_pc,
  input  logic [15:0] i_sp,
  input  logic [7:0]  i_flags,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [15:0] o_mem_addr,
  output logic [7:0]  o_mem_wdata,
  input  logic [7:0]  i_mem_rdata,
  input  logic        i_mem_rdy,
  output logic        o_busy,
  output logic [15:0] o_pc,
  output logic [15:0] o_sp,
  output logic        o_pc_load,
  output logic        o_sp_load,
  output logic        o_ie_clr,
  output logic [3:0]  o_cur_id
);
`ifdef IRQ_FLAGS_PUSH_EN
  localparam logic [15:0] SP_DEC = 16'd3;
  logic [7:0] r_flags;
`else
  localparam logic [15:0] SP_DEC = 16'd2;
  logic w_unused_flags;
  assign w_unused_flags = ^i_flags;
`endif
  state_t      r_state;
  logic [3:0]  r_id;
  logic [15:0] r_pc, r_sp, r_pc_out, r_sp_out, r_mem_addr;
  logic [7:0]  r_vec_lo, r_mem_wdata;
  logic        r_busy, r_mem_req, r_mem_we, r_pc_load, r_sp_load, r_ie_clr, r_ack;
  logic        w_boot, w_accept;
  assign w_boot   = i_next_id == INT_ID_RSTB;
  assign w_accept = i_next_on && (w_boot || (i_ie && i_boundary));
  assign o_ack       = r_ack;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_busy      = r_busy;
  assign o_pc        = r_pc_out;
  assign o_sp        = r_sp_out;
  assign o_pc_load   = r_pc_load;
  assign o_sp_load   = r_sp_load;
  assign o_ie_clr    = r_ie_clr;
  assign o_cur_id    = r_id;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_id        <= '0;
      r_pc        <= '0;
      r_sp        <= '0;
      r_vec_lo    <= '0;
      r_busy      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_pc_out    <= '0;
      r_sp_out    <= '0;
      r_pc_load   <= 1'b0;
      r_sp_load   <= 1'b0;
      r_ie_clr    <= 1'b0;
      r_ack       <= 1'b0;
`ifdef IRQ_FLAGS_PUSH_EN
      r_flags     <= '0;
`endif
    end else begin
      r_pc_load <= 1'b0;
      r_sp_load <= 1'b0;
      r_ie_clr  <= 1'b0;
      r_ack     <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_id      <= i_next_id;
          r_pc      <= i_pc;
          r_sp      <= i_sp;
          r_busy    <= 1'b1;
          r_mem_req <= 1'b1;
`ifdef IRQ_FLAGS_PUSH_EN
          r_flags   <= i_flags;
`endif
          // reset-boot skips the stack push entirely
          if (w_boot) begin
            r_state    <= S_VEC_LO;
            r_mem_we   <= 1'b0;
            r_mem_addr <= vec_addr(VEC_BASE, i_next_id, 1'b0);
          end else begin
            r_state     <= S_PUSH_HI;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= i_sp - 16'd1;
            r_mem_wdata <= i_pc[15:8];
          end
        end
        S_PUSH_HI: if (i_mem_rdy) begin
          r_state     <= S_PUSH_LO;
          r_mem_addr  <= r_sp - 16'd2;
          r_mem_wdata <= r_pc[7:0];
        end
`ifdef IRQ_FLAGS_PUSH_EN
        S_PUSH_LO: if (i_mem_rdy) begin
          r_state     <= S_PUSH_FL;
          r_mem_addr  <= r_sp - 16'd3;
          r_mem_wdata <= r_flags;
        end
        S_PUSH_FL: if (i_mem_rdy) begin
          r_state    <= S_VEC_LO;
          r_mem_we   <= 1'b0;
          r_mem_addr <= vec_addr(VEC_BASE, r_id, 1'b0);
        end
`else
        S_PUSH_LO: if (i_mem_rdy) begin
          r_state    <= S_VEC_LO;
          r_mem_we   <= 1'b0;
          r_mem_addr <= vec_addr(VEC_BASE, r_id, 1'b0);
        end
`endif
        S_VEC_LO: if (i_mem_rdy) begin
          r_state    <= S_VEC_HI;
          r_vec_lo   <= i_mem_rdata;
          r_mem_addr <= vec_addr(VEC_BASE, r_id, 1'b1);
        end
        S_VEC_HI: if (i_mem_rdy) begin
          r_state   <= S_LOAD;
          r_mem_req <= 1'b0;
          r_pc_out  <= {i_mem_rdata, r_vec_lo};
          r_pc_load <= 1'b1;
          r_ie_clr  <= 1'b1;
          if (r_id != INT_ID_RSTB) begin
            r_sp_load <= 1'b1;
            r_sp_out  <= r_sp - SP_DEC;
          end
        end
        S_LOAD: begin
          r_state <= S_DONE;
          r_ack   <= 1'b1;
        end
        S_DONE: r_state <= S_DRAIN;
        // hold off until the controller drops the serviced valid
        S_DRAIN: if (!i_next_on) begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_irq_dispatch.sv
// tb_irq_dispatch: table-driven vectors plus gating, wait-state and abort sequences for irq_dispatch.
// Memory transfers are checked against a scoreboard queue filled when each interrupt is driven.
module tb_irq_dispatch;
  import irq_pkg::*;
`ifdef IRQ_FLAGS_PUSH_EN
  localparam int FL = 1;
`else
  localparam int FL = 0;
`endif
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [3:0]  next_id = '0;
  logic        next_on = 1'b0, ie = 1'b0, boundary = 1'b0;
  logic [15:0] pc_in = '0, sp_in = '0;
  logic [7:0]  flags_in = '0, mem_rdata = '0;
  logic        mem_rdy = 1'b0;
  logic        ack, mem_req, mem_we, busy, pc_load, sp_load, ie_clr;
  logic [15:0] mem_addr, pc_out, sp_out;
  logic [7:0]  mem_wdata;
  logic [3:0]  cur_id;

  always #5 clk = ~clk;

  irq_dispatch dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_next_id(next_id), .i_next_on(next_on), .o_ack(ack),
    .i_ie(ie), .i_boundary(boundary), .i_pc(pc_in), .i_sp(sp_in), .i_flags(flags_in),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .i_mem_rdy(mem_rdy), .o_busy(busy), .o_pc(pc_out), .o_sp(sp_out),
    .o_pc_load(pc_load), .o_sp_load(sp_load), .o_ie_clr(ie_clr), .o_cur_id(cur_id)
  );

  typedef struct packed {logic we; logic [15:0] addr; logic [7:0] data;} mem_op_t;
  typedef struct {
    logic [3:0] id; logic [15:0] pc, sp; int nw;
    logic [15:0] e_pc, e_sp; int e_load, e_ack; logic e_spl;
  } vec_t;

  mem_op_t     exp_q[$];
  mem_op_t     cur, hold_op, e_op;
  logic [15:0] vt[16];
  int          nwait = 0, wcnt = 0;
  logic        held = 1'b0;
  int          n_cmp = 0, n_bad = 0;
  vec_t        vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, {20'd0, |pc_out, |sp_out, |mem_addr, |mem_wdata, busy, mem_req, mem_we,
               ack, pc_load, sp_load, ie_clr, |cur_id}, 32'd0);
  endtask

  // memory model: ready after nwait stall cycles, each completed transfer popped from the scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_rdy = 1'b0; wcnt = 0; held = 1'b0;
    end else if (mem_req) begin
      cur = '{mem_we, mem_addr, mem_we ? mem_wdata : 8'h00};
      if (held) chk("mem_hold", 32'(cur), 32'(hold_op));
      mem_rdata = mem_addr[0] ? vt[mem_addr[4:1]][15:8] : vt[mem_addr[4:1]][7:0];
      if (wcnt >= nwait) begin
        mem_rdy = 1'b1; wcnt = 0; held = 1'b0;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL mem_unexpected: got %h expected no transfer", cur);
        end else begin
          e_op = exp_q.pop_front();
          chk("mem_op", 32'(cur), 32'(e_op));
        end
      end else begin
        mem_rdy = 1'b0; wcnt++; held = 1'b1; hold_op = cur;
      end
    end else begin
      mem_rdy = 1'b0; wcnt = 0; held = 1'b0;
    end
  end

  task automatic push_ops(input logic [3:0] id, input logic [15:0] pc, input logic [15:0] sp);
    if (id != 4'h8) begin
      exp_q.push_back('{1'b1, sp - 16'd1, pc[15:8]});
      exp_q.push_back('{1'b1, sp - 16'd2, pc[7:0]});
      if (FL != 0) exp_q.push_back('{1'b1, sp - 16'd3, 8'h5A});
    end
    exp_q.push_back('{1'b0, 16'hFFE0 + {11'd0, id, 1'b0}, 8'h00});
    exp_q.push_back('{1'b0, 16'hFFE1 + {11'd0, id, 1'b0}, 8'h00});
  endtask

  task automatic run_irq(input vec_t v);
    int k, load_k, ack_k, n_ack, n_spl, n_pcl;
    nwait = v.nw;
    push_ops(v.id, v.pc, v.sp);
    @(negedge clk);
    next_id = v.id; next_on = 1'b1; pc_in = v.pc; sp_in = v.sp; flags_in = 8'h5A;
    ie = 1'b1; boundary = 1'b1;
    load_k = -1; ack_k = -1; n_ack = 0; n_spl = 0; n_pcl = 0; k = 0;
    while (k < 80 && !(ack_k > 0 && k >= ack_k + 5)) begin
      @(negedge clk); k++;
      if (k == 1) begin
        chk("busy_accept", 32'(busy), 32'd1);
        chk("cur_id", 32'(cur_id), 32'(v.id));
        next_id = ~v.id; pc_in = ~v.pc; sp_in = ~v.sp; flags_in = 8'hA5;
      end
      if (pc_load) begin
        n_pcl++; load_k = k;
        chk("pc_out", 32'(pc_out), 32'(v.e_pc));
        chk("ie_clr", 32'(ie_clr), 32'd1);
        chk("sp_load_with_pc", 32'(sp_load), 32'(v.e_spl));
        if (v.e_spl) chk("sp_out", 32'(sp_out), 32'(v.e_sp));
      end
      if (sp_load) n_spl++;
      if (ack) begin n_ack++; if (ack_k < 0) ack_k = k; end
    end
    chk("load_cycle", 32'(load_k), 32'(v.e_load));
    chk("ack_cycle", 32'(ack_k), 32'(v.e_ack));
    chk("ack_count", 32'(n_ack), 32'd1);
    chk("pc_load_count", 32'(n_pcl), 32'd1);
    chk("sp_load_count", 32'(n_spl), 32'(v.e_spl));
    chk("busy_drain", 32'(busy), 32'd1);
    next_on = 1'b0;
    @(negedge clk);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("mem_q_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int k;
    logic found;
    for (int i = 0; i < 16; i++) vt[i] = 16'h2000 + 16'(i) * 16'h0102;
    vt[8] = 16'hC000;
    vecs[0] = '{4'h8, 16'h1234, 16'h0300, 0, 16'hC000, 16'h0000, 3, 4, 1'b0};
    vecs[1] = '{4'h5, 16'h1234, 16'h0200, 0, 16'h250A, 16'h01FE - 16'(FL), 5 + FL, 6 + FL, 1'b1};
    vecs[2] = '{4'h2, 16'hABCD, 16'h0000, 0, 16'h2204, 16'hFFFE - 16'(FL), 5 + FL, 6 + FL, 1'b1};
    vecs[3] = '{4'hF, 16'h00FF, 16'h8001, 2, 16'h2F1E, 16'h7FFF - 16'(FL),
                5 + FL + 2 * (4 + FL), 6 + FL + 2 * (4 + FL), 1'b1};
    vecs[4] = '{4'h0, 16'hFFFF, 16'h0001, 1, 16'h2000, 16'hFFFF - 16'(FL),
                5 + FL + (4 + FL), 6 + FL + (4 + FL), 1'b1};
    vecs[5] = '{4'h8, 16'h0000, 16'h0000, 2, 16'hC000, 16'h0000, 7, 8, 1'b0};
    vecs[6] = '{4'h3, 16'h8000, 16'h0002, 0, 16'h2306, 16'h0000 - 16'(FL), 5 + FL, 6 + FL, 1'b1};

    repeat (2) @(negedge clk);
    chk_zero("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("idle_after_reset");

    for (int i = 0; i < 7; i++) run_irq(vecs[i]);

    // gating: enable low, then boundary low, hold the request pending
    nwait = 0;
    push_ops(4'h2, 16'h4321, 16'h0100);
    @(negedge clk);
    next_id = 4'h2; next_on = 1'b1; pc_in = 16'h4321; sp_in = 16'h0100; flags_in = 8'h5A;
    ie = 1'b0; boundary = 1'b1;
    repeat (10) begin @(negedge clk); chk("gate_ie", 32'(busy), 32'd0); end
    ie = 1'b1; boundary = 1'b0;
    repeat (3) begin @(negedge clk); chk("gate_boundary", 32'(busy), 32'd0); end
    boundary = 1'b1;
    @(negedge clk);
    chk("gate_open", 32'(busy), 32'd1);
    found = 1'b0; k = 0;
    while (!found && k < 20) begin @(negedge clk); k++; found = ack; end
    chk("gate_ack_seen", 32'(found), 32'd1);
    chk("gate_ack_cycle", 32'(k + 1), 32'(6 + FL));
    next_on = 1'b0;
    repeat (2) @(negedge clk);
    chk("gate_idle", 32'(busy), 32'd0);
    chk("gate_q_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // abort: reset while the vector high byte read is stalled
    nwait = 2;
    push_ops(4'h5, 16'h1111, 16'h0400);
    @(negedge clk);
    next_id = 4'h5; next_on = 1'b1; pc_in = 16'h1111; sp_in = 16'h0400;
    found = 1'b0; k = 0;
    while (!found && k < 40) begin
      @(negedge clk); k++;
      found = mem_req && !mem_we && mem_addr == 16'hFFEB;
    end
    chk("abort_reach_vec_hi", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_zero("abort_outputs");
    next_on = 1'b0;
    found = 1'b0;
    repeat (3) begin @(negedge clk); found = found | pc_load; end
    chk("abort_no_pc_load", 32'(found), 32'd0);
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk_zero("abort_idle");

    run_irq(vecs[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
